// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with whole-line refill over a
// single-outstanding valid/ready word interface and a full-invalidate flush.
module instruction_cache #(
  parameter int ADDR_WIDTH   = 17,
  parameter int INST_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  read_valid,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_done,
  output logic [INST_WIDTH-1:0] read_data,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [INST_WIDTH-1:0] mem_resp_data
);
  localparam int TAG_WIDTH = ADDR_WIDTH - 2 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << OFFSET_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [OFFSET_WIDTH-1:0] cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINES-1:0]        line_vld;
  logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
  logic [INST_WIDTH-1:0]   data_mem [LINES][WORDS];

  logic [TAG_WIDTH-1:0]    req_tag, cur_tag;
  logic [INDEX_WIDTH-1:0]  req_idx, cur_idx;
  logic [OFFSET_WIDTH-1:0] req_off, cur_off;
  logic                    hit, req_fire, fill_we, accept;

  assign req_tag  = read_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx  = read_addr[2+OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_off  = read_addr[2 +: OFFSET_WIDTH];
  assign cur_tag  = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign cur_idx  = addr_q[2+OFFSET_WIDTH +: INDEX_WIDTH];
  assign cur_off  = addr_q[2 +: OFFSET_WIDTH];
  assign hit      = line_vld[req_idx] && (tag_mem[req_idx] == req_tag);
  assign req_fire = mem_req_valid && mem_req_ready;
  assign accept   = (state == IDLE) && read_valid && !flush;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fill_we  = 1'b0;
    unique case (state)
      IDLE: if (read_valid) begin
        state_nx = hit ? DONE : REQ;
        cnt_nx   = '0;
      end
      REQ:  if (req_fire) state_nx = WAIT;
      WAIT: if (mem_resp_valid) begin
        fill_we = 1'b1;
        if (&cnt) state_nx = DONE;
        else begin
          cnt_nx   = cnt + 1'b1;
          state_nx = REQ;
        end
      end
      DONE:  state_nx = IDLE;
      DRAIN: if (mem_resp_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A flush must still swallow the response of any request already accepted.
    if (flush) begin
      fill_we = 1'b0;
      if ((state == WAIT && !mem_resp_valid) || (state == REQ && req_fire) ||
          (state == DRAIN && !mem_resp_valid))
        state_nx = DRAIN;
      else
        state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      line_vld      <= '0;
      read_done     <= 1'b0;
      read_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      addr_q        <= '0;
    end else if (rdy) begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      read_done     <= (state_nx == DONE);
      mem_req_valid <= (state_nx == REQ);
      if (accept) addr_q <= read_addr;
      if (state_nx == REQ) begin
        if (state == IDLE) mem_req_addr <= {req_tag, req_idx, cnt_nx, 2'b00};
        else               mem_req_addr <= {cur_tag, cur_idx, cnt_nx, 2'b00};
      end
      if (accept && hit)
        read_data <= data_mem[req_idx][req_off];
      else if (fill_we && cnt == cur_off)
        read_data <= mem_resp_data;
      if (flush)
        line_vld <= '0;
      else if (fill_we && (&cnt))
        line_vld[cur_idx] <= 1'b1;
    end
  end

  // Arrays carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      data_mem[cur_idx][cnt] <= mem_resp_data;
      if (&cnt) tag_mem[cur_idx] <= cur_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: refill, hit, conflict, backpressure,
// flush-drain, rdy freeze and mid-refill reset.
module tb_instruction_cache;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, read_valid;
  logic [16:0] read_addr;
  logic        read_done;
  logic [31:0] read_data;
  logic        mem_req_valid;
  logic [16:0] mem_req_addr;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  instruction_cache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .read_valid(read_valid), .read_addr(read_addr),
    .read_done(read_done), .read_data(read_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (read_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_word(input logic [16:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("req_valid", 32'(mem_req_valid), 32'd1);
    chk("req_addr", 32'(mem_req_addr), 32'(a));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic finish_read(input logic [31:0] exp, input int d0);
    chk("read_done", 32'(read_done), 32'd1);
    chk("read_data", read_data, exp);
    read_valid = 1'b0;
    tick();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("done_low", 32'(read_done), 32'd0);
  endtask

  task automatic refill(input logic [16:0] ra, input logic [16:0] base,
                        input logic [31:0] w0, w1, w2, w3, exp);
    int d0;
    d0 = done_cnt;
    read_valid = 1'b1;
    read_addr  = ra;
    tick();
    serve_word(base, w0);
    serve_word(base + 17'd4, w1);
    serve_word(base + 17'd8, w2);
    serve_word(base + 17'd12, w3);
    finish_read(exp, d0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, 32'(read_done), 32'd0);
    chk({tag, "_data"}, read_data, 32'd0);
    chk({tag, "_rvld"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_raddr"}, 32'(mem_req_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; read_valid = 1'b0; read_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Cold miss then a hit on the same line
    refill(17'h00000, 17'h00000, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);
    read_valid = 1'b1; read_addr = 17'h00008;
    tick();
    chk("hit_done", 32'(read_done), 32'd1);
    chk("hit_data", read_data, 32'h33);
    chk("hit_noreq", 32'(mem_req_valid), 32'd0);
    read_valid = 1'b0;
    tick();
    chk("hit_done_low", 32'(read_done), 32'd0);

    // Conflict on index 0
    refill(17'h00100, 17'h00100, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA1);
    refill(17'h00000, 17'h00000, 32'h55, 32'h66, 32'h77, 32'h88, 32'h55);

    // Backpressure on the first request
    d0 = done_cnt;
    read_valid = 1'b1; read_addr = 17'h00208;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_addr", 32'(mem_req_addr), 32'h200);
      chk("bp_nodone", 32'(read_done), 32'd0);
      tick();
    end
    serve_word(17'h00200, 32'hB1);
    serve_word(17'h00204, 32'hB2);
    serve_word(17'h00208, 32'hB3);
    serve_word(17'h0020C, 32'hB4);
    finish_read(32'hB3, d0);

    // Flush while waiting on the second response
    read_valid = 1'b1; read_addr = 17'h00004;
    tick();
    serve_word(17'h00000, 32'hC1);
    chk("fl_req2_addr", 32'(mem_req_addr), 32'h4);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    read_valid = 1'b0;
    d0 = done_cnt;
    chk("fl_rvld", 32'(mem_req_valid), 32'd0);
    chk("fl_done", 32'(read_done), 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("drain_nodone", 32'(done_cnt - d0), 32'd0);
    chk("drain_rvld", 32'(mem_req_valid), 32'd0);
    refill(17'h00004, 17'h00000, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD2);

    // rdy low while a response pulses in WAIT
    d0 = done_cnt;
    read_valid = 1'b1; read_addr = 17'h00014;
    tick();
    serve_word(17'h00010, 32'hE1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rdy = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_rvld", 32'(mem_req_valid), 32'd0);
      chk("rdy_nodone", 32'(read_done), 32'd0);
    end
    mem_resp_valid = 1'b0;
    rdy = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hE2;
    tick();
    mem_resp_valid = 1'b0;
    serve_word(17'h00018, 32'hE3);
    serve_word(17'h0001C, 32'hE4);
    finish_read(32'hE2, d0);
    read_valid = 1'b1; read_addr = 17'h00010;
    tick();
    chk("rdy_hit_done", 32'(read_done), 32'd1);
    chk("rdy_hit_data", read_data, 32'hE1);
    read_valid = 1'b0;
    tick();

    // Reset in the middle of a refill
    read_valid = 1'b1; read_addr = 17'h00020;
    tick();
    serve_word(17'h00020, 32'hF1);
    serve_word(17'h00024, 32'hF2);
    serve_word(17'h00028, 32'hF3);
    chk("rst_req4_addr", 32'(mem_req_addr), 32'h2C);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    read_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk_idle_outputs("midrst");
    tick();
    refill(17'h00020, 17'h00020, 32'h91, 32'h92, 32'h93, 32'h94, 32'h91);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
